// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: read-owner encoding,
// the read byte-enable code and the wait-counter width helper.
package bus_arbiter_pkg;

  // Which master owns an outstanding read.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  // An all-zero byte-enable pattern marks a read access.
  localparam logic [3:0] BYTEEN_RD = 4'b0000;

  // Wait-counter width: clog2(MAX_WAIT+1), at least one bit so MAX_WAIT=0 still elaborates.
  function automatic int cnt_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/bus_arb_starve_cnt.sv
// Saturating starvation counter for the DMA master. Counts consecutive
// cycles in which DMA requests but is not granted; at_max tells the
// arbiter to force a DMA grant. MAX_WAIT=0 keeps at_max permanently high,
// which gives DMA strict priority.
module bus_arb_starve_cnt
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic gnt,
  output logic at_max
);

  localparam int            CW    = cnt_width(MAX_WAIT);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear on grant or no request, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (!req || gnt) begin
      cnt_d = '0;
    end else if (cnt_q != MAX_C) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register, asynchronously cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == MAX_C);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter (CPU + DMA) in front of the Bridge data port.
// Handshake: a master raises req with addr/wdata/byteen and holds them
// stable until the cycle its gnt is high; gnt is the single-cycle
// acceptance and the access appears on s_* in that same cycle. Read data
// returns on s_rdata one cycle later and is steered to the issuing master
// with an rvalid pulse. Writes (non-zero byteen) get no response.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic [3:0]        c_byteen,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_byteen,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [3:0]        s_byteen,
  input  logic [DATA_W-1:0] s_rdata
);

  logic   at_max;
  logic   rd_pend_q, rd_pend_d;
  owner_e rd_own_q, rd_own_d;

  bus_arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .req    (d_req),
    .gnt    (d_gnt),
    .at_max (at_max)
  );

  // Grant decision: CPU wins unless DMA has starved long enough; no grants in reset.
  always_comb begin
    d_gnt = reset & d_req & (~c_req | at_max);
    c_gnt = reset & c_req & ~d_gnt;
  end

  // Slave mux: winner's access, or all-zero on idle so no stale byteen leaks.
  always_comb begin
    s_valid  = c_gnt | d_gnt;
    s_addr   = '0;
    s_wdata  = '0;
    s_byteen = 4'b0000;
    if (d_gnt) begin
      s_addr   = d_addr;
      s_wdata  = d_wdata;
      s_byteen = d_byteen;
    end else if (c_gnt) begin
      s_addr   = c_addr;
      s_wdata  = c_wdata;
      s_byteen = c_byteen;
    end
  end

  // Read tracking next-state: remember a read issue and who made it.
  always_comb begin
    rd_pend_d = s_valid && (s_byteen == BYTEEN_RD);
    rd_own_d  = rd_own_q;
    if (rd_pend_d) begin
      rd_own_d = d_gnt ? OWN_DMA : OWN_CPU;
    end
  end

  // Read tracking registers; reset drops any in-flight return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend_q <= 1'b0;
      rd_own_q  <= OWN_CPU;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_own_q  <= rd_own_d;
    end
  end

  // Return routing: owner sees s_rdata and rvalid, the other master sees zero.
  always_comb begin
    c_rvalid = rd_pend_q & (rd_own_q == OWN_CPU);
    d_rvalid = rd_pend_q & (rd_own_q == OWN_DMA);
    c_rdata  = (rd_own_q == OWN_CPU) ? s_rdata : '0;
    d_rdata  = (rd_own_q == OWN_DMA) ? s_rdata : '0;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: table of directed vectors, hand
// sequences for reset and data routing, then held-request random traffic
// compared each cycle against a streak/queue model of the arbitration rules.
module tb_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          c_req, d_req;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata;
  logic [3:0]    c_byteen, d_byteen;
  logic          c_gnt, d_gnt, c_rvalid, d_rvalid;
  logic [DW-1:0] c_rdata, d_rdata;
  logic          s_valid;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [3:0]    s_byteen;
  logic [DW-1:0] s_rdata;

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_addr(c_addr), .c_wdata(c_wdata), .c_byteen(c_byteen),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_byteen(d_byteen),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_byteen(s_byteen),
    .s_rdata(s_rdata)
  );

  // ---------------- scoreboard / model state ----------------
  int n_vec = 0;
  int n_err = 0;
  int streak;             // consecutive denied DMA-request cycles
  logic [1:0] exp_q[$];   // per issued cycle: {read issued, owner is DMA}
  logic m_cg, m_dg;       // model grants of the last cycle
  logic a_cg, a_dg, a_cv, a_dv;  // sampled DUT values of the last cycle

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Called at posedge+1: drive, check at negedge, advance model at posedge.
  task automatic cycle(input logic cr, input logic [31:0] ca, input logic [31:0] cw,
                       input logic [3:0] cb, input logic dr, input logic [31:0] da,
                       input logic [31:0] dw, input logic [3:0] db, input logic [31:0] rd);
    logic [1:0]  ret;
    logic [31:0] ea, ew;
    logic [3:0]  eb;
    logic        issue_rd;
    c_req = cr; c_addr = ca; c_wdata = cw; c_byteen = cb;
    d_req = dr; d_addr = da; d_wdata = dw; d_byteen = db;
    s_rdata = rd;
    @(negedge clk);
    m_dg = reset && dr && (!cr || streak >= MW);
    m_cg = reset && cr && !m_dg;
    ea = m_dg ? da : (m_cg ? ca : 32'h0);
    ew = m_dg ? dw : (m_cg ? cw : 32'h0);
    eb = m_dg ? db : (m_cg ? cb : 4'h0);
    ret = (exp_q.size() > 0) ? exp_q[0] : 2'b00;
    chk("c_gnt", 32'(c_gnt), 32'(m_cg));
    chk("d_gnt", 32'(d_gnt), 32'(m_dg));
    chk("s_valid", 32'(s_valid), 32'(m_cg | m_dg));
    chk("s_addr", s_addr, ea);
    chk("s_wdata", s_wdata, ew);
    chk("s_byteen", 32'(s_byteen), 32'(eb));
    chk("c_rvalid", 32'(c_rvalid), 32'(ret[1] & ~ret[0]));
    chk("d_rvalid", 32'(d_rvalid), 32'(ret[1] & ret[0]));
    if (ret[1] && !ret[0]) begin
      chk("c_rdata", c_rdata, rd);
      chk("d_rdata_zero", d_rdata, 32'h0);
    end
    if (ret[1] && ret[0]) begin
      chk("d_rdata", d_rdata, rd);
      chk("c_rdata_zero", c_rdata, 32'h0);
    end
    a_cg = c_gnt; a_dg = d_gnt; a_cv = c_rvalid; a_dv = d_rvalid;
    issue_rd = (m_cg || m_dg) && (eb == 4'h0);
    @(posedge clk);
    exp_q.delete();
    if (reset) begin
      if (!dr || m_dg) streak = 0;
      else if (streak < MW) streak++;
      exp_q.push_back({issue_rd, m_dg});
    end else begin
      streak = 0;
    end
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        cr, dr;
    logic [3:0]  cb, db;
    logic [31:0] rd;
    logic        e_cg, e_dg, e_cv, e_dv;
  } vec_t;

  vec_t tbl[10];

  // random-phase held fields
  logic          r_cr, r_dr;
  logic [31:0]   r_ca, r_cw, r_da, r_dw;
  logic [3:0]    r_cb, r_db;

  initial begin
    // contention: CPU,CPU,CPU,DMA,CPU,CPU (writes, no responses)
    tbl[0] = '{1, 1, 4'hF, 4'hF, 32'h0, 1, 0, 0, 0};
    tbl[1] = '{1, 1, 4'hF, 4'hF, 32'h0, 1, 0, 0, 0};
    tbl[2] = '{1, 1, 4'hF, 4'hF, 32'h0, 1, 0, 0, 0};
    tbl[3] = '{1, 1, 4'hF, 4'hF, 32'h0, 0, 1, 0, 0};
    tbl[4] = '{1, 1, 4'hF, 4'hF, 32'h0, 1, 0, 0, 0};
    tbl[5] = '{1, 1, 4'hF, 4'hF, 32'h0, 1, 0, 0, 0};
    // idle: clears the wait streak
    tbl[6] = '{0, 0, 4'h0, 4'h0, 32'h0, 0, 0, 0, 0};
    // interleaved reads: CPU read, then DMA read with CPU return, then DMA return
    tbl[7] = '{1, 0, 4'h0, 4'h0, 32'h0, 1, 0, 0, 0};
    tbl[8] = '{0, 1, 4'h0, 4'h0, 32'hA, 0, 1, 1, 0};
    tbl[9] = '{0, 0, 4'h0, 4'h0, 32'hB, 0, 0, 0, 1};

    streak = 0;
    reset = 1'b0;
    // reset state: requests present but nothing granted, no rvalid
    cycle(1, 32'h100, 32'h1, 4'h0, 1, 32'h200, 32'h2, 4'h0, 32'h0);
    chk("rst_c_gnt", 32'(a_cg), 32'h0);
    chk("rst_d_gnt", 32'(a_dg), 32'h0);
    cycle(0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 32'h0);
    reset = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].cr, 32'h1000 + 32'(i), 32'hC0 + 32'(i), tbl[i].cb,
            tbl[i].dr, 32'h2000 + 32'(i), 32'hD0 + 32'(i), tbl[i].db, tbl[i].rd);
      chk($sformatf("tbl%0d_c_gnt", i), 32'(a_cg), 32'(tbl[i].e_cg));
      chk($sformatf("tbl%0d_d_gnt", i), 32'(a_dg), 32'(tbl[i].e_dg));
      chk($sformatf("tbl%0d_c_rvalid", i), 32'(a_cv), 32'(tbl[i].e_cv));
      chk($sformatf("tbl%0d_d_rvalid", i), 32'(a_dv), 32'(tbl[i].e_dv));
    end

    // CPU-only read at 0x7F00, data 0x12345678 returns next cycle
    cycle(1, 32'h0000_7F00, 32'h0, 4'h0, 0, 0, 0, 4'h0, 32'h0);
    chk("cpu_rd_saddr", s_addr, 32'h0000_7F00);
    cycle(0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 32'h1234_5678);
    chk("cpu_rd_data", c_rdata, 32'h1234_5678);
    chk("cpu_rd_valid", 32'(a_cv), 32'h1);

    // DMA write: forwarded unchanged, no response
    cycle(0, 0, 0, 4'h0, 1, 32'h7F10, 32'h5, 4'hF, 32'h0);
    chk("dma_wr_gnt", 32'(a_dg), 32'h1);
    cycle(0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 32'hFFFF_FFFF);
    chk("dma_wr_norsp", 32'(a_dv | a_cv), 32'h0);
    chk("idle_byteen", 32'(s_byteen), 32'h0);

    // DMA drops mid-wait: streak restarts, DMA needs three fresh denials
    cycle(1, 32'h10, 0, 4'hF, 1, 32'h20, 0, 4'hF, 0);
    cycle(1, 32'h10, 0, 4'hF, 1, 32'h20, 0, 4'hF, 0);
    cycle(1, 32'h10, 0, 4'hF, 0, 32'h20, 0, 4'hF, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 32'h10, 0, 4'hF, 1, 32'h20, 0, 4'hF, 0);
      chk($sformatf("drop_d_gnt%0d", i), 32'(a_dg), (i == 3) ? 32'h1 : 32'h0);
    end

    // reset mid-read: return is discarded and the streak restarts
    cycle(1, 32'h10, 0, 4'hF, 1, 32'h20, 0, 4'hF, 0);  // build a streak
    cycle(1, 32'h7F00, 0, 4'h0, 1, 32'h20, 0, 4'hF, 0);
    #2;
    reset = 1'b0;
    exp_q.delete();
    streak = 0;
    #1;
    chk("rst_mid_c_rvalid", 32'(c_rvalid), 32'h0);
    chk("rst_mid_c_gnt", 32'(c_gnt), 32'h0);
    chk("rst_mid_s_valid", 32'(s_valid), 32'h0);
    cycle(1, 32'h10, 0, 4'hF, 1, 32'h20, 0, 4'hF, 32'h55);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1, 32'h10, 0, 4'hF, 1, 32'h20, 0, 4'hF, 0);
      chk($sformatf("post_rst_d_gnt%0d", i), 32'(a_dg), (i == 3) ? 32'h1 : 32'h0);
    end

    // randomized traffic; non-granted masters hold their request stable
    r_cr = 0; r_dr = 0;
    r_ca = 0; r_cw = 0; r_cb = 0; r_da = 0; r_dw = 0; r_db = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(r_cr && !m_cg)) begin
        r_cr = 1'($urandom_range(0, 1));
        r_ca = $urandom; r_cw = $urandom;
        r_cb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      if (!(r_dr && !m_dg)) begin
        r_dr = 1'($urandom_range(0, 3) != 0);
        r_da = $urandom; r_dw = $urandom;
        r_db = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      cycle(r_cr, r_ca, r_cw, r_cb, r_dr, r_da, r_dw, r_db, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
